mem_access_stage: RTL and testbench

//  MEM stage of the MIPS32 pipeline, directly downstream of RegEXMEM. Executes LW/LB/LBU/SW/SB from the EX/MEM fields

---
 rtl/mem_bus_if.sv | 12 +
 rtl/mem_access_stage.sv | 114 +++++++++++
 tb/tb_mem_access_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if.sv
// mem_bus_if: req/ack data bus between the MEM stage (master) and memory (slave); carries BusReq/BusWE/BusAddr/BusBE/BusWData out and BusRData/BusAck back
interface mem_bus_if;
  logic        BusReq;
  logic        BusWE;
  logic [31:0] BusAddr;
  logic [3:0]  BusBE;
  logic [31:0] BusWData;
  logic [31:0] BusRData;
  logic        BusAck;
  modport master (output BusReq, BusWE, BusAddr, BusBE, BusWData, input BusRData, BusAck);
  modport slave (input BusReq, BusWE, BusAddr, BusBE, BusWData, output BusRData, BusAck);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS32 MEM stage; runs LW/LB/LBU/SW/SB over bus (mem_bus_if.master), stalls via StallReq, flags AdEL/AdES and timeout BusError, feeds MEM/WB (WBDataOutput, RegDestOutput, RegWriteOutput, BadVAddrOutput)
module mem_access_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXResultInput,
  input  logic [31:0] RegDataBInput,
  input  logic        MemReadInput,
  input  logic        MemWriteInput,
  input  logic [1:0]  MemReadSelectInput,
  input  logic        MemWriteSelectInput,
  input  logic [5:0]  RegDestInput,
  input  logic        RegWriteInput,
  input  logic        MemToRegInput,
  mem_bus_if.master   bus,
  output logic        StallReq,
  output logic [31:0] WBDataOutput,
  output logic [5:0]  RegDestOutput,
  output logic        RegWriteOutput,
  output logic        AdEL,
  output logic        AdES,
  output logic [31:0] BadVAddrOutput,
  output logic        BusError
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(TIMEOUT);
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, load_q, load_d, rdata_ext;
  logic [3:0]    be_q, be_d;
  logic [7:0]    rbyte;
  logic          is_load, is_store, word_ld, mis, start;
  assign is_store = MemWriteInput;
  assign is_load  = MemReadInput & ~MemWriteInput;
  // selects 00 and 11 both mean LW
  assign word_ld  = ~^MemReadSelectInput;
  assign mis      = |EXResultInput[1:0] & ((is_load & word_ld) | (is_store & ~MemWriteSelectInput));
  assign AdEL     = is_load & mis;
  assign AdES     = is_store & mis;
  assign start    = (state_q == IDLE) & (is_load | is_store) & ~mis;
  assign StallReq = start | (state_q == BUSY);
  assign rbyte    = 8'(bus.BusRData >> {EXResultInput[1:0], 3'b000});
  assign rdata_ext = MemReadSelectInput == 2'b01 ? {{24{rbyte[7]}}, rbyte} :
                     MemReadSelectInput == 2'b10 ? {24'b0, rbyte} : bus.BusRData;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    err_d   = err_q;
    if (state_q == IDLE && start) begin
      state_d = BUSY;
      req_d   = 1'b1;
      we_d    = is_store;
      addr_d  = {EXResultInput[31:2], 2'b00};
      be_d    = is_store & MemWriteSelectInput ? 4'b0001 << EXResultInput[1:0] : 4'b1111;
      wdata_d = ~is_store ? 32'b0 : MemWriteSelectInput ? {4{RegDataBInput[7:0]}} : RegDataBInput;
    end else if (state_q == BUSY) begin
      if (bus.BusAck || cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = DONE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        load_d  = bus.BusAck ? rdata_ext : 32'b0;
        err_d   = ~bus.BusAck;
      end else
        cnt_d = cnt_q + 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end
  assign bus.BusReq     = req_q;
  assign bus.BusWE      = we_q;
  assign bus.BusAddr    = addr_q;
  assign bus.BusBE      = be_q;
  assign bus.BusWData   = wdata_q;
  assign BusError       = err_q;
  assign WBDataOutput   = MemToRegInput ? load_q : EXResultInput;
  assign RegDestOutput  = RegDestInput;
  assign RegWriteOutput = RegWriteInput & ~AdEL & ~err_q;
  assign BadVAddrOutput = EXResultInput;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage (TIMEOUT=8)
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] EXResultInput = '0, RegDataBInput = '0;
  logic        MemReadInput = 1'b0, MemWriteInput = 1'b0, MemWriteSelectInput = 1'b0;
  logic [1:0]  MemReadSelectInput = '0;
  logic [5:0]  RegDestInput = 6'd5;
  logic        RegWriteInput = 1'b0, MemToRegInput = 1'b0;
  logic        StallReq, RegWriteOutput, AdEL, AdES, BusError;
  logic [31:0] WBDataOutput, BadVAddrOutput;
  logic [5:0]  RegDestOutput;
  mem_bus_if bus ();
  mem_access_stage #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .EXResultInput(EXResultInput), .RegDataBInput(RegDataBInput),
    .MemReadInput(MemReadInput), .MemWriteInput(MemWriteInput), .MemReadSelectInput(MemReadSelectInput),
    .MemWriteSelectInput(MemWriteSelectInput), .RegDestInput(RegDestInput), .RegWriteInput(RegWriteInput),
    .MemToRegInput(MemToRegInput), .bus(bus), .StallReq(StallReq), .WBDataOutput(WBDataOutput),
    .RegDestOutput(RegDestOutput), .RegWriteOutput(RegWriteOutput), .AdEL(AdEL), .AdES(AdES),
    .BadVAddrOutput(BadVAddrOutput), .BusError(BusError)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] wb;
    logic        rw;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] addr;
    int          stall;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  int checks = 0, failures = 0;
  int obs_stall;
  bit obs_done;
  logic [31:0] obs_wb, obs_wdata, obs_addr;
  logic [3:0]  obs_be;
  logic        obs_rw, obs_err, obs_we;
  task automatic drive(input logic rd, input logic wr, input logic [1:0] rsel, input logic wsel,
                       input logic [31:0] addr, input logic [31:0] wdat, input logic m2r, input logic rw);
    @(posedge clk);
    #1;
    MemReadInput = rd; MemWriteInput = wr; MemReadSelectInput = rsel; MemWriteSelectInput = wsel;
    EXResultInput = addr; RegDataBInput = wdat; MemToRegInput = m2r; RegWriteInput = rw;
  endtask
  task automatic run_access(input int k, input logic [31:0] rdata);
    int busy_n = 0;
    obs_stall = 0; obs_done = 0;
    obs_be = 'x; obs_addr = 'x; obs_wdata = 'x; obs_we = 'x;
    for (int c = 0; c < 40 && !obs_done; c++) begin
      @(negedge clk);
      if (StallReq) obs_stall++;
      if (bus.BusReq) begin
        busy_n++;
        obs_be = bus.BusBE; obs_addr = bus.BusAddr; obs_wdata = bus.BusWData; obs_we = bus.BusWE;
      end
      bus.BusRData = rdata;
      bus.BusAck = bus.BusReq && busy_n == k;
      if (!StallReq && obs_stall > 0) begin
        obs_wb = WBDataOutput; obs_rw = RegWriteOutput; obs_err = BusError; obs_done = 1;
      end
    end
    bus.BusAck = 1'b0;
    MemReadInput = 1'b0;
    MemWriteInput = 1'b0;
  endtask
  task automatic test_reset;
    MemToRegInput = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({bus.BusReq, bus.BusWE, bus.BusBE, BusError, StallReq} !== 8'b0) begin failures++; $display("FAIL reset_ctrl got=%b want=0", {bus.BusReq, bus.BusWE, bus.BusBE, BusError, StallReq}); end
    checks++; if ({bus.BusAddr, bus.BusWData} !== 64'b0) begin failures++; $display("FAIL reset_bus got=%h want=0", {bus.BusAddr, bus.BusWData}); end
    checks++; if (WBDataOutput !== 32'b0) begin failures++; $display("FAIL reset_load got=%h want=0", WBDataOutput); end
    checks++; if (RegDestOutput !== 6'd5) begin failures++; $display("FAIL regdest got=%0d want=5", RegDestOutput); end
  endtask
  task automatic test_lw;
    drive(1, 0, 2'b00, 0, 32'h100, 32'h0, 1, 1);
    sbq.push_back('{32'hDEADBEEF, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h100, 5});
    run_access(4, 32'hDEADBEEF);
    e = sbq.pop_front();
    checks++; if (!obs_done || obs_stall != e.stall) begin failures++; $display("FAIL lw_stall got=%0d done=%0d want=%0d", obs_stall, obs_done, e.stall); end
    checks++; if (obs_wb !== e.wb) begin failures++; $display("FAIL lw_wb got=%h want=%h", obs_wb, e.wb); end
    checks++; if ({obs_be, obs_we, obs_addr} !== {e.be, e.we, e.addr}) begin failures++; $display("FAIL lw_bus got=%b/%b/%h want=%b/%b/%h", obs_be, obs_we, obs_addr, e.be, e.we, e.addr); end
    checks++; if ({obs_rw, obs_err} !== {e.rw, e.err}) begin failures++; $display("FAIL lw_ctl got=%b%b want=%b%b", obs_rw, obs_err, e.rw, e.err); end
  endtask
  task automatic test_byte_loads;
    drive(1, 0, 2'b01, 0, 32'h103, 32'h0, 1, 1);
    sbq.push_back('{32'hFFFFFF80, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h100, 2});
    run_access(1, 32'h80112233);
    e = sbq.pop_front();
    checks++; if (!obs_done || obs_stall != e.stall) begin failures++; $display("FAIL lb_stall got=%0d want=%0d", obs_stall, e.stall); end
    checks++; if (obs_wb !== e.wb) begin failures++; $display("FAIL lb_wb got=%h want=%h", obs_wb, e.wb); end
    checks++; if ({obs_addr, obs_be} !== {e.addr, e.be}) begin failures++; $display("FAIL lb_bus got=%h/%b want=%h/%b", obs_addr, obs_be, e.addr, e.be); end
    drive(1, 0, 2'b10, 0, 32'h103, 32'h0, 1, 1);
    sbq.push_back('{32'h00000080, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h100, 3});
    run_access(2, 32'h80112233);
    e = sbq.pop_front();
    checks++; if (!obs_done || obs_wb !== e.wb || obs_stall != e.stall) begin failures++; $display("FAIL lbu_wb got=%h/%0d want=%h/%0d", obs_wb, obs_stall, e.wb, e.stall); end
    drive(1, 0, 2'b01, 0, 32'h101, 32'h0, 1, 1);
    sbq.push_back('{32'h00000022, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h100, 2});
    run_access(1, 32'h80112233);
    e = sbq.pop_front();
    checks++; if (!obs_done || obs_wb !== e.wb) begin failures++; $display("FAIL lb_pos_wb got=%h want=%h", obs_wb, e.wb); end
  endtask
  task automatic test_stores;
    drive(0, 1, 2'b00, 1, 32'h202, 32'h000000A5, 0, 0);
    sbq.push_back('{32'h202, 1'b0, 1'b0, 4'b0100, 32'hA5A5A5A5, 1'b1, 32'h200, 3});
    run_access(2, 32'h0);
    e = sbq.pop_front();
    checks++; if (!obs_done || {obs_be, obs_we} !== {e.be, e.we}) begin failures++; $display("FAIL sb_be got=%b/%b want=%b/%b", obs_be, obs_we, e.be, e.we); end
    checks++; if (obs_wdata !== e.wdata) begin failures++; $display("FAIL sb_wdata got=%h want=%h", obs_wdata, e.wdata); end
    checks++; if ({obs_wb, obs_rw} !== {e.wb, e.rw}) begin failures++; $display("FAIL sb_wb got=%h/%b want=%h/%b", obs_wb, obs_rw, e.wb, e.rw); end
    drive(1, 1, 2'b00, 0, 32'h204, 32'h12345678, 0, 1);
    sbq.push_back('{32'h204, 1'b1, 1'b0, 4'b1111, 32'h12345678, 1'b1, 32'h204, 2});
    run_access(1, 32'h0);
    e = sbq.pop_front();
    checks++; if (!obs_done || {obs_be, obs_we, obs_wdata, obs_addr, obs_rw} !== {e.be, e.we, e.wdata, e.addr, e.rw}) begin failures++; $display("FAIL sw_bus got=%b/%b/%h/%h/%b want=%b/%b/%h/%h/%b", obs_be, obs_we, obs_wdata, obs_addr, obs_rw, e.be, e.we, e.wdata, e.addr, e.rw); end
  endtask
  task automatic test_misaligned;
    bit req_seen = 0;
    drive(0, 1, 2'b00, 0, 32'h301, 32'h0, 0, 0);
    #1;
    checks++; if ({AdES, AdEL, StallReq} !== 3'b100) begin failures++; $display("FAIL ades got=%b want=100", {AdES, AdEL, StallReq}); end
    checks++; if (BadVAddrOutput !== 32'h301) begin failures++; $display("FAIL badvaddr got=%h want=00000301", BadVAddrOutput); end
    repeat (3) begin @(negedge clk); if (bus.BusReq || StallReq) req_seen = 1; end
    checks++; if (req_seen) begin failures++; $display("FAIL ades_noreq got=1 want=0"); end
    drive(1, 0, 2'b00, 0, 32'h302, 32'h0, 0, 1);
    #1;
    checks++; if ({AdEL, AdES, StallReq, RegWriteOutput} !== 4'b1000) begin failures++; $display("FAIL adel got=%b want=1000", {AdEL, AdES, StallReq, RegWriteOutput}); end
    checks++; if (BadVAddrOutput !== 32'h302) begin failures++; $display("FAIL adel_badvaddr got=%h want=00000302", BadVAddrOutput); end
    MemReadInput = 1'b0;
  endtask
  task automatic test_nonmem;
    drive(0, 0, 2'b00, 0, 32'hCAFE0001, 32'h0, 0, 1);
    #1;
    checks++; if ({StallReq, WBDataOutput, RegWriteOutput} !== {1'b0, 32'hCAFE0001, 1'b1}) begin failures++; $display("FAIL nonmem got=%b/%h/%b want=0/cafe0001/1", StallReq, WBDataOutput, RegWriteOutput); end
  endtask
  task automatic test_timeout;
    drive(1, 0, 2'b00, 0, 32'h400, 32'h0, 1, 1);
    sbq.push_back('{32'h0, 1'b0, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h400, 9});
    run_access(0, 32'h55555555);
    e = sbq.pop_front();
    checks++; if (!obs_done || obs_stall != e.stall) begin failures++; $display("FAIL to_stall got=%0d want=%0d", obs_stall, e.stall); end
    checks++; if ({obs_err, obs_rw, obs_wb} !== {e.err, e.rw, e.wb}) begin failures++; $display("FAIL to_err got=%b/%b/%h want=%b/%b/%h", obs_err, obs_rw, obs_wb, e.err, e.rw, e.wb); end
    @(negedge clk);
    checks++; if (BusError !== 1'b0) begin failures++; $display("FAIL to_clear got=%b want=0", BusError); end
  endtask
  task automatic test_ack_on_timeout;
    drive(1, 0, 2'b00, 0, 32'h404, 32'h0, 1, 1);
    sbq.push_back('{32'h0BADF00D, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h404, 9});
    run_access(8, 32'h0BADF00D);
    e = sbq.pop_front();
    checks++; if (!obs_done || {obs_wb, obs_err, obs_rw} !== {e.wb, e.err, e.rw} || obs_stall != e.stall) begin failures++; $display("FAIL ack_last got=%h/%b/%b/%0d want=%h/%b/%b/%0d", obs_wb, obs_err, obs_rw, obs_stall, e.wb, e.err, e.rw, e.stall); end
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      int k = $urandom_range(1, 4);
      logic [31:0] rd = $urandom;
      drive(1, 0, 2'b00, 0, 32'h500 + 32'(i * 4), 32'h0, 1, 1);
      sbq.push_back('{rd, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h500 + 32'(i * 4), k + 1});
      run_access(k, rd);
      e = sbq.pop_front();
      checks++; if (!obs_done || {obs_wb, obs_addr} !== {e.wb, e.addr} || obs_stall != e.stall) begin failures++; $display("FAIL b2b%0d got=%h/%h/%0d want=%h/%h/%0d", i, obs_wb, obs_addr, obs_stall, e.wb, e.addr, e.stall); end
    end
  endtask
  task automatic test_rst_busy;
    int busy_n = 0;
    drive(1, 0, 2'b00, 0, 32'h600, 32'h0, 1, 1);
    for (int c = 0; c < 10 && busy_n < 2; c++) begin
      @(negedge clk);
      if (bus.BusReq) busy_n++;
    end
    checks++; if (busy_n != 2) begin failures++; $display("FAIL rst_busy_reach got=%0d want=2", busy_n); end
    rst = 1'b1;
    MemReadInput = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({bus.BusReq, StallReq, BusError, bus.BusBE, bus.BusAddr, WBDataOutput} !== '0) begin failures++; $display("FAIL rst_busy got=%b/%b/%b/%b/%h/%h want=0", bus.BusReq, StallReq, BusError, bus.BusBE, bus.BusAddr, WBDataOutput); end
    bus.BusRData = 32'h77777777;
    bus.BusAck = 1'b1;
    @(negedge clk);
    bus.BusAck = 1'b0;
    checks++; if ({bus.BusReq, StallReq, BusError, WBDataOutput} !== '0) begin failures++; $display("FAIL late_ack got=%b/%b/%b/%h want=0", bus.BusReq, StallReq, BusError, WBDataOutput); end
  endtask
  initial begin
    bus.BusAck = 1'b0;
    bus.BusRData = '0;
    test_reset;
    test_lw;
    test_byte_loads;
    test_stores;
    test_misaligned;
    test_nonmem;
    test_timeout;
    test_ack_on_timeout;
    test_back_to_back;
    test_rst_busy;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
